la_iopwrseq: RTL and testbench

LA_IOPWRSEQ -- requirements
Module: la_iopwrseq

---
 rtl/la_iopwrseq_pkg.sv | 21 ++
 rtl/la_iopwrsync.sv | 37 +++
 rtl/la_iopwrseq.sv | 173 +++++++++++++++++
 tb/tb_la_iopwrseq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/la_iopwrseq_pkg.sv
// -----------------------------------------------------------------------------
// la_iopwrseq_pkg
//   Shared definitions for the io-ring power sequencer.
//   - iopwr_state_t : sequencer states (IDLE, WAIT, UP, ON, DOWN)
//   - DLYW_DEF      : default width of the step-delay input / step counter
//   - TOW_DEF       : default width of the power-good timeout counter
// -----------------------------------------------------------------------------
package la_iopwrseq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      UP,
      ON,
      DOWN
   } iopwr_state_t;

   localparam int DLYW_DEF = 8;
   localparam int TOW_DEF  = 16;

endpackage

// File: rtl/la_iopwrsync.sv
// -----------------------------------------------------------------------------
// la_iopwrsync
//   Multi-stage synchronizer for a single asynchronous level.
//   Ports:
//     clk    - destination clock
//     nreset - asynchronous active-low reset, clears every stage
//     din    - asynchronous input level
//     dout   - synchronized level, STAGES cycles of latency
//   Parameters:
//     STAGES - number of flops in the chain (>= 2)
// -----------------------------------------------------------------------------
module la_iopwrsync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic nreset,
   input  logic din,
   output logic dout
);

   if (STAGES < 2) begin : g_bad_stages
      $error("la_iopwrsync: STAGES must be at least 2");
   end

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], din};
      end
   end

   assign dout = ff[STAGES-1];

endmodule

// File: rtl/la_iopwrseq.sv
// -----------------------------------------------------------------------------
// la_iopwrseq
//   Io-ring power sequencer. Ramps a thermometer-coded enable vector up one
//   segment at a time once the pad supply reports good, and ramps it back
//   down (MSB first) when the request drops or the supply goes away.
//   Ports:
//     clk     - block clock
//     nreset  - asynchronous active-low reset (release synchronized upstream)
//     en      - level request: 1 = ring up, 0 = ring down
//     pwrgood - asynchronous vddio-good from the pad supply
//     dly     - idle cycles between ring steps (sampled at load/reload)
//     ioring  - thermometer-coded ring segment enables (registered)
//     ready   - ring fully up
//     busy    - ramping up or down
//     err     - sticky power-good timeout flag
//   Build option:
//     LA_IOPWRSEQ_TIMEOUT_EN - when defined, a TOW-bit counter bounds the
//     wait for power-good; expiry sets err and returns to IDLE. When
//     undefined, err is tied low and WAIT waits indefinitely.
// -----------------------------------------------------------------------------
module la_iopwrseq
   import la_iopwrseq_pkg::*;
#(
   parameter           PROP  = "DEFAULT",
   parameter           SIDE  = "NO",
   parameter int       RINGW = 8,
   parameter int       DLYW  = DLYW_DEF,
   parameter int       TOW   = TOW_DEF
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            en,
   input  logic            pwrgood,
   input  logic [DLYW-1:0] dly,
   output logic [RINGW-1:0] ioring,
   output logic            ready,
   output logic            busy,
   output logic            err
);

   if (RINGW < 1 || RINGW > 64) begin : g_bad_ringw
      $error("la_iopwrseq: RINGW must be in 1..64");
   end
   if (SIDE != "NO" && SIDE != "SO" && SIDE != "EA" && SIDE != "WE") begin : g_bad_side
      $error("la_iopwrseq: SIDE must be NO, SO, EA or WE");
   end
   if (PROP == "") begin : g_bad_prop
      $error("la_iopwrseq: PROP must not be empty");
   end
   if (DLYW < 1 || TOW < 1) begin : g_bad_widths
      $error("la_iopwrseq: DLYW and TOW must be at least 1");
   end

   logic            pwrgood_s;
   iopwr_state_t    state;
   logic [DLYW-1:0] cnt;
   logic [RINGW-1:0] up_nxt;
   logic [RINGW-1:0] dn_nxt;
   logic            abort;

   la_iopwrsync #(
      .STAGES (2)
   ) u_sync (
      .clk    (clk),
      .nreset (nreset),
      .din    (pwrgood),
      .dout   (pwrgood_s)
   );

   // Stepping by shift instead of indexing keeps ioring gap-free by
   // construction; the top set bit plays the role of the step index.
   assign up_nxt = (ioring << 1) | RINGW'(1);
   assign dn_nxt = ioring >> 1;
   assign abort  = !en || !pwrgood_s;

`ifdef LA_IOPWRSEQ_TIMEOUT_EN
   logic [TOW-1:0] tocnt;
   logic [TOW-1:0] tonext;
   assign tonext = tocnt + TOW'(1);
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state  <= IDLE;
         ioring <= '0;
         ready  <= 1'b0;
         busy   <= 1'b0;
         cnt    <= '0;
`ifdef LA_IOPWRSEQ_TIMEOUT_EN
         err    <= 1'b0;
         tocnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               ioring <= '0;
               ready  <= 1'b0;
               busy   <= 1'b0;
`ifdef LA_IOPWRSEQ_TIMEOUT_EN
               tocnt  <= '0;
               if (!en) begin
                  err <= 1'b0;
               end
`endif
               if (en && !err) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (!en) begin
                  state <= IDLE;
               end else if (pwrgood_s) begin
                  state <= UP;
                  cnt   <= dly;
                  busy  <= 1'b1;
               end
`ifdef LA_IOPWRSEQ_TIMEOUT_EN
               else if (&tonext) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  tocnt <= tonext;
               end
`endif
            end
            UP: begin
               if (abort) begin
                  state <= DOWN;
                  cnt   <= dly;
               end else if (cnt == '0) begin
                  ioring <= up_nxt;
                  cnt    <= dly;
                  if (&up_nxt) begin
                     state <= ON;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - DLYW'(1);
               end
            end
            ON: begin
               // ready rises the cycle after the last segment is enabled
               if (abort) begin
                  state <= DOWN;
                  cnt   <= dly;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end else begin
                  ready <= 1'b1;
               end
            end
            DOWN: begin
               // en is deliberately ignored here; the ramp always completes
               if (ioring == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == '0) begin
                  ioring <= dn_nxt;
                  cnt    <= dly;
               end else begin
                  cnt <= cnt - DLYW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_la_iopwrseq.sv
// -----------------------------------------------------------------------------
// tb_la_iopwrseq
//   Directed bench for la_iopwrseq with RINGW=8, DLYW=8, TOW=4.
//   Inputs change on the falling edge; outputs are checked on the falling
//   edge after a given number of rising edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_la_iopwrseq;

   logic       clk;
   logic       nreset;
   logic       en;
   logic       pwrgood;
   logic [7:0] dly;
   logic [7:0] ioring;
   logic       ready;
   logic       busy;
   logic       err;

   int unsigned tests;
   int unsigned fails;

   la_iopwrseq #(
      .PROP  ("DEFAULT"),
      .SIDE  ("NO"),
      .RINGW (8),
      .DLYW  (8),
      .TOW   (4)
   ) dut (
      .clk     (clk),
      .nreset  (nreset),
      .en      (en),
      .pwrgood (pwrgood),
      .dly     (dly),
      .ioring  (ioring),
      .ready   (ready),
      .busy    (busy),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        pg;
      logic [7:0]  dly;
      int unsigned n;
      logic [7:0]  io;
      logic        rdy;
      logic        bsy;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic e, input logic p, input logic [7:0] d,
                               input int unsigned n, input logic [7:0] io,
                               input logic r, input logic b);
      vec_t v;
      v.en = e; v.pg = p; v.dly = d; v.n = n; v.io = io; v.rdy = r; v.bsy = b;
      return v;
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all(input string nm, input logic [7:0] io,
                            input logic r, input logic b, input logic e);
      check({nm, " ioring"}, ioring, io);
      check({nm, " ready"}, 8'(ready), 8'(r));
      check({nm, " busy"}, 8'(busy), 8'(b));
      check({nm, " err"}, 8'(err), 8'(e));
   endtask

   task automatic do_reset;
      nreset  = 1'b0;
      en      = 1'b0;
      pwrgood = 1'b0;
      dly     = 8'd0;
      #1;
      @(negedge clk);
      nreset = 1'b1;
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      nreset  = 1'b0;
      en      = 1'b0;
      pwrgood = 1'b0;
      dly     = 8'd0;

      // Table trace: ramp up at dly=3, fast ramp down, dly=0 ramp up,
      // en reasserted during DOWN, then normal re-entry.
      tv.push_back(mk(0, 0, 8'd3,  2, 8'h00, 0, 0)); // 0  idle after reset
      tv.push_back(mk(1, 1, 8'd3,  6, 8'h00, 0, 1)); // 1  UP, counting
      tv.push_back(mk(1, 1, 8'd3,  1, 8'h01, 0, 1)); // 2  bit0 at edge 7
      tv.push_back(mk(1, 1, 8'd3,  3, 8'h01, 0, 1)); // 3  spacing gap
      tv.push_back(mk(1, 1, 8'd3,  1, 8'h03, 0, 1)); // 4  bit1 4 cycles later
      tv.push_back(mk(1, 1, 8'd3, 24, 8'hFF, 0, 0)); // 5  full, ready lags
      tv.push_back(mk(1, 1, 8'd3,  1, 8'hFF, 1, 0)); // 6  ready
      tv.push_back(mk(1, 1, 8'd3,  5, 8'hFF, 1, 0)); // 7  hold ON
      tv.push_back(mk(0, 1, 8'd0,  1, 8'hFF, 0, 1)); // 8  DOWN
      tv.push_back(mk(0, 1, 8'd0,  1, 8'h7F, 0, 1)); // 9
      tv.push_back(mk(0, 1, 8'd0,  1, 8'h3F, 0, 1)); // 10
      tv.push_back(mk(0, 1, 8'd0,  5, 8'h01, 0, 1)); // 11
      tv.push_back(mk(0, 1, 8'd0,  1, 8'h00, 0, 1)); // 12 still DOWN
      tv.push_back(mk(0, 1, 8'd0,  1, 8'h00, 0, 0)); // 13 IDLE
      tv.push_back(mk(1, 1, 8'd0,  1, 8'h00, 0, 0)); // 14 WAIT
      tv.push_back(mk(1, 1, 8'd0,  1, 8'h00, 0, 1)); // 15 UP
      tv.push_back(mk(1, 1, 8'd0,  1, 8'h01, 0, 1)); // 16 one bit per cycle
      tv.push_back(mk(1, 1, 8'd0,  7, 8'hFF, 0, 0)); // 17
      tv.push_back(mk(1, 1, 8'd0,  1, 8'hFF, 1, 0)); // 18
      tv.push_back(mk(0, 1, 8'd1,  1, 8'hFF, 0, 1)); // 19 DOWN, dly=1
      tv.push_back(mk(1, 1, 8'd1,  2, 8'h7F, 0, 1)); // 20 en ignored
      tv.push_back(mk(1, 1, 8'd1, 14, 8'h00, 0, 1)); // 21
      tv.push_back(mk(1, 1, 8'd1,  1, 8'h00, 0, 0)); // 22 IDLE
      tv.push_back(mk(1, 1, 8'd1,  1, 8'h00, 0, 0)); // 23 WAIT
      tv.push_back(mk(1, 1, 8'd1,  1, 8'h00, 0, 1)); // 24 UP
      tv.push_back(mk(1, 1, 8'd1,  2, 8'h01, 0, 1)); // 25

      // Reset state
      #1;
      check_all("reset", 8'h00, 0, 0, 0);
      do_reset;

      for (int i = 0; i < tv.size(); i++) begin
         en      = tv[i].en;
         pwrgood = tv[i].pg;
         dly     = tv[i].dly;
         run(tv[i].n);
         check_all($sformatf("vec%0d", i), tv[i].io, tv[i].rdy, tv[i].bsy, 1'b0);
      end

      // pwrgood lost mid ramp-up at ioring=07
      do_reset;
      en = 1'b1; pwrgood = 1'b1; dly = 8'd3;
      run(15);
      check_all("pgdrop start", 8'h07, 0, 1, 0);
      pwrgood = 1'b0;
      run(3);
      check_all("pgdrop abort", 8'h07, 0, 1, 0);
      run(4);
      check_all("pgdrop 03", 8'h03, 0, 1, 0);
      run(4);
      check_all("pgdrop 01", 8'h01, 0, 1, 0);
      run(4);
      check_all("pgdrop 00", 8'h00, 0, 1, 0);
      run(1);
      check_all("pgdrop idle", 8'h00, 0, 0, 0);

      // Reset pulsed mid-sequence at ioring=1F
      do_reset;
      en = 1'b1; pwrgood = 1'b1; dly = 8'd0;
      run(8);
      check_all("rst pre", 8'h1F, 0, 1, 0);
      nreset = 1'b0;
      #1;
      check_all("rst async", 8'h00, 0, 0, 0);
      @(negedge clk);
      nreset = 1'b1;
      run(3);
      check_all("rst restart", 8'h00, 0, 1, 0);
      run(1);
      check_all("rst bit0", 8'h01, 0, 1, 0);

`ifdef LA_IOPWRSEQ_TIMEOUT_EN
      // Timeout with TOW=4: 15 WAIT cycles then err
      do_reset;
      en = 1'b1; pwrgood = 1'b0; dly = 8'd0;
      run(15);
      check_all("to pre", 8'h00, 0, 0, 0);
      run(1);
      check_all("to err", 8'h00, 0, 0, 1);
      pwrgood = 1'b1;
      run(5);
      check_all("to hold", 8'h00, 0, 0, 1);
      en = 1'b0;
      run(1);
      check_all("to clear", 8'h00, 0, 0, 0);
      en = 1'b1;
      run(2);
      check_all("to reenter", 8'h00, 0, 1, 0);
`else
      // Without the timeout WAIT persists and err stays low
      do_reset;
      en = 1'b1; pwrgood = 1'b0; dly = 8'd0;
      run(40);
      check_all("nto wait", 8'h00, 0, 0, 0);
      pwrgood = 1'b1;
      run(3);
      check_all("nto up", 8'h00, 0, 1, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
